// File: rtl/dffram_256x16_wrap_if.sv
// RAM port bundle: enable, byte write enables, address, write data, read data.
// master drives the request side; slave is the RAM and returns Do0.
interface dffram_256x16_wrap_if #(
  parameter int WSIZE = 2
);
  logic               EN0;
  logic [WSIZE-1:0]   WE0;
  logic [9:0]         A0;
  logic [WSIZE*8-1:0] Di0;
  logic [WSIZE*8-1:0] Do0;

  modport master (
    output EN0,
    output WE0,
    output A0,
    output Di0,
    input  Do0
  );

  modport slave (
    input  EN0,
    input  WE0,
    input  A0,
    input  Di0,
    output Do0
  );
endinterface

// File: rtl/dffram_256x16_wrap.sv
// 256x16 flop RAM, per-byte writes, registered read-first read port.
// Ports: clk_i, rst_ni (sync, active-low), bus (slave), optional VPWR/VGND.
module dffram_256x16_wrap #(
  parameter int WSIZE = 2
) (
`ifdef USE_POWER_PINS
  inout  wire  VPWR,
  inout  wire  VGND,
`endif
  input  logic clk_i,
  input  logic rst_ni,
  dffram_256x16_wrap_if.slave bus
);

  localparam int DW = WSIZE * 8;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] do_q;
  logic [7:0]    addr;
  logic          unused_hi;

  // Upper address bits alias onto the same 256 words.
  assign addr      = bus.A0[7:0];
  assign unused_hi = ^bus.A0[9:8];
  assign bus.Do0   = do_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      do_q <= '0;
    end else if (bus.EN0) begin
      do_q <= mem[addr];
    end
  end

  // Storage is never reset; a write sampled during reset is dropped.
  for (genvar b = 0; b < WSIZE; b++) begin : g_lane
    always_ff @(posedge clk_i) begin
      if (rst_ni && bus.EN0 && bus.WE0[b]) begin
        mem[addr][b*8 +: 8] <= bus.Di0[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dffram_256x16_wrap.sv
// Bench for dffram_256x16_wrap: directed plan plus random traffic,
// checked each cycle against a word-array reference model.
module tb_dffram_256x16_wrap;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  dffram_256x16_wrap_if #(.WSIZE(2)) bus ();

  dffram_256x16_wrap #(.WSIZE(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Reference: word array with a per-bit "known" mask for never-written data.
  logic [15:0] m_dat [256];
  logic [15:0] m_knw [256];
  logic [15:0] exp_do = 16'h0;
  logic [15:0] exp_msk = 16'h0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_dat[i] = 16'h0;
      m_knw[i] = 16'h0;
    end
  end

  always @(posedge clk_i) begin
    automatic int a = int'(bus.A0[7:0]);
    if (!rst_ni) begin
      exp_do  = 16'h0;
      exp_msk = 16'hFFFF;
    end else if (bus.EN0) begin
      exp_do  = m_dat[a];
      exp_msk = m_knw[a];
      if (bus.WE0[0]) begin
        m_dat[a][7:0] = bus.Di0[7:0];
        m_knw[a][7:0] = 8'hFF;
      end
      if (bus.WE0[1]) begin
        m_dat[a][15:8] = bus.Di0[15:8];
        m_knw[a][15:8] = 8'hFF;
      end
    end
  end

  always @(negedge clk_i) begin
    if (exp_msk != 16'h0) begin
      n_chk++;
      if ((bus.Do0 & exp_msk) !== (exp_do & exp_msk)) begin
        n_fail++;
        $display("FAIL model t=%0t Do0=%h expected=%h mask=%h",
                 $time, bus.Do0, exp_do, exp_msk);
      end
    end
  end

  task automatic op(input logic en, input logic [1:0] we,
                    input logic [9:0] a, input logic [15:0] d);
    @(negedge clk_i);
    bus.EN0 = en;
    bus.WE0 = we;
    bus.A0  = a;
    bus.Di0 = d;
  endtask

  task automatic lit(input string nm, input logic [15:0] e);
    n_chk++;
    if (bus.Do0 !== e) begin
      n_fail++;
      $display("FAIL %s Do0=%h expected=%h", nm, bus.Do0, e);
    end
  endtask

  initial begin
    bus.EN0 = 1'b0;
    bus.WE0 = 2'b00;
    bus.A0  = 10'h0;
    bus.Di0 = 16'h0;
    op(0, 0, 0, 0);
    op(0, 0, 0, 0);
    lit("reset", 16'h0000);
    rst_ni = 1'b1;

    for (int i = 0; i < 256; i++) op(1, 2'b11, 10'(i), 16'(i));
    for (int i = 0; i < 256; i++) begin
      op(1, 2'b00, 10'(i), 16'h0);
      if (i > 0) lit("fill", 16'(i - 1));
    end
    op(0, 0, 0, 0);
    lit("fill_last", 16'd255);

    op(1, 2'b11, 10'h010, 16'hFFFF);
    op(1, 2'b01, 10'h010, 16'h1234);
    op(1, 2'b00, 10'h010, 16'h0);
    op(0, 0, 0, 0);
    lit("lane_lo", 16'hFF34);
    op(1, 2'b10, 10'h010, 16'hAB00);
    op(1, 2'b00, 10'h010, 16'h0);
    op(0, 0, 0, 0);
    lit("lane_hi", 16'hAB34);

    op(1, 2'b11, 10'h003, 16'h5555);
    op(1, 2'b00, 10'h003, 16'h0);
    op(0, 2'b11, 10'h003, 16'hAAAA);
    lit("en_read", 16'h5555);
    op(0, 0, 0, 0);
    lit("en_hold", 16'h5555);
    op(1, 2'b00, 10'h003, 16'h0);
    op(0, 0, 0, 0);
    lit("en_mem", 16'h5555);

    op(1, 2'b11, 10'h007, 16'h00F7);
    op(1, 2'b00, 10'h007, 16'h0);
    lit("rdw_old", 16'h0007);
    op(0, 0, 0, 0);
    lit("rdw_new", 16'h00F7);

    op(1, 2'b11, 10'h305, 16'hBEEF);
    op(1, 2'b00, 10'h005, 16'h0);
    op(0, 0, 0, 0);
    lit("alias", 16'hBEEF);

    op(1, 2'b11, 10'h009, 16'hDEAD);
    rst_ni = 1'b0;
    op(1, 2'b11, 10'h009, 16'hDEAD);
    lit("rst_1", 16'h0000);
    op(1, 2'b00, 10'h009, 16'h0);
    rst_ni = 1'b1;
    lit("rst_2", 16'h0000);
    op(0, 0, 0, 0);
    lit("rst_keep", 16'h0009);

    for (int n = 0; n < 3000; n++) begin
      automatic logic [9:0] a;
      a = 10'($urandom);
      if ($urandom_range(0, 3) != 0) a[7:0] = 8'($urandom_range(0, 15));
      op(($urandom_range(0, 7) != 0), 2'($urandom), a, 16'($urandom));
      rst_ni = ($urandom_range(0, 49) != 0);
    end
    rst_ni = 1'b1;
    op(0, 0, 0, 0);
    op(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dffram_256x16_wrap.md
# dffram_256x16_wrap

Single-port 256-word x 16-bit synchronous RAM wrapper with per-byte write enables and a registered read port. It wraps a flip-flop-based storage array (DFFRAM style) behind the codebase's standard clock/reset naming. It serves as the local data store inside the SPI cache datapath. Read data is valid one clock after the address is presented.

## Interface
Parameters:
- WSIZE, 2, number of byte lanes; data width is WSIZE*8 = 16. Only 2 is supported.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- EN0  input  1  port enable; no read or write occurs when 0
- WE0  input  2  byte write enables: WE0[0] -> Di0[7:0], WE0[1] -> Di0[15:8]
- A0  input  10  word address; only A0[7:0] is used, and A0[9:8] are ignored
- Di0  input  16  write data
- Do0  output  16  registered read data
- VPWR, VGND  inout  1  power pins, present only when USE_POWER_PINS is defined

## Operation
- Storage: 256 words x 16 bits, held in flops and addressed by A0[7:0].
- Write: on a rising edge with rst_ni=1, EN0=1, and WE0[b]=1, byte b of mem[A0[7:0]] is loaded from Di0[8b+7:8b]. Bytes whose WE0 bit is 0 are unchanged.
- Read: on a rising edge with rst_ni=1 and EN0=1, Do0 is loaded with mem[A0[7:0]]. A read happens on every enabled cycle, whether or not a write is also occurring.
- Read-during-write to the same address is read-first: Do0 gets the contents from before the edge, and the new data is visible on the next read.
- EN0=0: memory and Do0 both hold their values. WE0 is ignored.
- Reset: while rst_ni=0 at a rising edge, Do0 is cleared to 16'h0000 and no write occurs. Memory contents are not cleared, and their power-up value is undefined (X in simulation).
- Address aliasing: A0 = 10'h1xx, 10'h2xx, and 10'h3xx all map to the same word as 10'h0xx.

## Timing
- Write latency: data is stored at the rising edge where WE0 is sampled. A read issued on the next cycle returns it.
- Read latency: 1 cycle. A0 is sampled at edge N, and Do0 is valid after edge N and stable until edge N+1.
- Back-to-back writes and reads at full clock rate are supported, with no stall or handshake.
- Reset mid-operation: a write sampled in a cycle with rst_ni=0 is dropped. Do0 is 0 after that edge, and normal operation resumes on the first edge with rst_ni=1.
- Do0 reset value: 16'h0000.
- There are no combinational paths from any input to Do0.

## Test plan
- Fill and readback: write mem[i]=i for i=0..255 with WE0=2'b11 and EN0=1, one per cycle. Then read i=0..255, sampling at the following negedge -> Do0 == i for every i.
- Byte lanes: write 16'hFFFF to address 8'h10. Then write 16'h1234 with WE0=2'b01 -> read returns 16'hFF34. Then write 16'hAB00 with WE0=2'b10 -> read returns 16'hAB34.
- Enable gating: write 16'h5555 to address 3. Write 16'hAAAA to address 3 with EN0=0 -> Do0 holds its previous value, and a later read returns 16'h5555.
- Read-during-write: with mem[7]=16'h0007, write 16'h00F7 to address 7 and read in the same cycle -> Do0 = 16'h0007. The next read returns 16'h00F7.
- Address aliasing: write 16'hBEEF with A0=10'h305 -> a read with A0=10'h005 returns 16'hBEEF.
- Reset: with Do0 nonzero, assert rst_ni=0 for 2 cycles while driving a write of 16'hDEAD to address 9 (old value 16'h0009) -> Do0 = 0 during reset. After release, a read of address 9 returns 16'h0009.
